// File: rtl/clock_divider.sv
// Game Boy clock generator. A 32-bit phase accumulator advances by a
// mode-dependent increment every sclk edge; each carry out of bit 31 toggles
// gclk, so gclk averages the target frequency while every high/low phase is a
// whole number of sclk cycles. The mode switch keeps the phase running, so a
// speed change never produces a phase shorter than one sclk period.
module clock_divider #(
  parameter int unsigned SYSTEM_CLOCK = 25000000
) (
  input  logic sclk,
  input  logic rst,
  input  logic cgbMode,
  output logic gclk
);

  // gclk toggles twice per output period, so the toggle rates are twice the
  // Game Boy clock rates: 2 * 4194304 and 2 * 8388608.
  localparam logic [63:0] TOGGLE_DMG_HZ = 64'd8388608;
  localparam logic [63:0] TOGGLE_CGB_HZ = 64'd16777216;

  // Guard the divisor so a zero clock reaches the elaboration error below
  // instead of a divide-by-zero while evaluating the constants.
  localparam logic [63:0] SCLK_HZ = 64'(SYSTEM_CLOCK);
  localparam logic [63:0] DIVISOR = (SCLK_HZ == 64'd0) ? 64'd1 : SCLK_HZ;

  // floor(2^32 * toggle_rate / sclk_rate), evaluated in 64 bits.
  localparam logic [63:0] INC_DMG_WIDE = (TOGGLE_DMG_HZ << 32) / DIVISOR;
  localparam logic [63:0] INC_CGB_WIDE = (TOGGLE_CGB_HZ << 32) / DIVISOR;
  localparam logic [31:0] INC_DMG      = INC_DMG_WIDE[31:0];
  localparam logic [31:0] INC_CGB      = INC_CGB_WIDE[31:0];

  // The double-speed increment only fits in 32 bits when sclk is faster than
  // the toggle rate it has to produce.
  generate
    if (SYSTEM_CLOCK <= 32'd16777216) begin : g_clock_too_slow
      $error("clock_divider: SYSTEM_CLOCK must exceed 16777216 Hz");
    end
  endgenerate

  logic [31:0] acc;
  logic        mode_reg;
  logic [31:0] inc;
  logic [32:0] sum;

  // Pick the increment from the registered mode and form the next phase with
  // its carry; the carry is the toggle request for gclk.
  always_comb begin
    inc = mode_reg ? INC_CGB : INC_DMG;
    sum = {1'b0, acc} + {1'b0, inc};
  end

  // Advance the phase, toggle gclk on overflow and sample the mode input, so a
  // mode change takes effect one edge after it is seen.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      acc      <= 32'd0;
      gclk     <= 1'b0;
      mode_reg <= 1'b0;
    end else begin
      acc      <= sum[31:0];
      gclk     <= gclk ^ sum[32];
      mode_reg <= cgbMode;
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider at SYSTEM_CLOCK = 25 MHz: reset table, random mode
// stimulus against an overflow-count reference model, frequency windows,
// phase-length limits, mode toggling and an asynchronous mid-cycle reset.
module tb_clock_divider;

  localparam int unsigned SYS = 25000000;
  localparam logic [63:0] REF_INC_DMG = 64'd1441151880;
  localparam logic [63:0] REF_INC_CGB = 64'd2882303761;

  logic sclk = 1'b0;
  logic rst = 1'b1;
  logic cgbMode = 1'b0;
  logic gclk;

  int total = 0;
  int bad = 0;

  clock_divider #(.SYSTEM_CLOCK(SYS)) dut (
    .sclk   (sclk),
    .rst    (rst),
    .cgbMode(cgbMode),
    .gclk   (gclk)
  );

  // ---------------- clock / reset ----------------
  always #5 sclk = ~sclk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo,
                             input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- reference model ----------------
  // gclk is the parity of the number of full 2^32 wraps of the total phase
  // accumulated since reset; the increment used at an edge comes from the
  // mode value seen at the previous edge (DMG right after reset).
  logic [63:0] m_total;
  logic        m_prev_mode;

  task automatic model_reset();
    m_total     = 64'd0;
    m_prev_mode = 1'b0;
  endtask

  task automatic model_edge(input logic cur_mode, output logic exp_g);
    m_total     = m_total + (m_prev_mode ? REF_INC_CGB : REF_INC_DMG);
    m_prev_mode = cur_mode;
    exp_g       = m_total[32];
  endtask

  // ---------------- scoreboard and phase statistics ----------------
  logic [0:0] exp_q[$];
  logic       st_last;
  int         st_run, st_min, st_max, st_rises;
  bit         st_seen;

  task automatic stats_reset();
    st_last  = 1'b0;
    st_run   = 0;
    st_seen  = 1'b0;
    st_min   = 1000;
    st_max   = 0;
    st_rises = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic mode);
    rst     = 1'b1;
    cgbMode = mode;
    repeat (2) tick();
    check("reset_gclk", gclk, 0);
    rst = 1'b0;
    model_reset();
    stats_reset();
    exp_q.delete();
  endtask

  task automatic run_edge(input logic mode, input string name);
    logic e;
    logic [0:0] exp_v;
    cgbMode = mode;
    model_edge(mode, e);
    exp_q.push_back(e);
    tick();
    exp_v = exp_q.pop_front();
    check(name, gclk, exp_v);
    if (gclk !== st_last) begin
      if (st_seen) begin
        if (st_run < st_min) st_min = st_run;
        if (st_run > st_max) st_max = st_run;
      end
      st_seen = 1'b1;
      st_run  = 1;
      if (gclk === 1'b1) st_rises++;
    end else begin
      st_run++;
    end
    st_last = gclk;
  endtask

  // Accept rising-edge counts within one of n * target / SYS.
  task automatic freq_check(input string name, input longint rises, input longint n,
                            input longint target);
    longint q, r, lo, hi;
    q  = (n * target) / SYS;
    r  = (n * target) % SYS;
    lo = (r == 0) ? q - 1 : q;
    hi = q + 1;
    check_range(name, rises, lo, hi);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic rst_before;
    logic mode;
    logic exp_gclk;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic m;
    bit   found;
    int   remaining, len;

    // DMG from reset: overflow on edge 3 and edge 6.
    vecs[0]  = '{1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0};
    // CGB held through reset: edge 1 still adds the DMG step, then CGB steps
    // overflow on edges 2, 4 and 5.
    vecs[6]  = '{1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b1};

    #2;
    check("reset_at_start", gclk, 0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst_before) do_reset(vecs[i].mode);
      cgbMode = vecs[i].mode;
      tick();
      check($sformatf("vec%0d", i), gclk, vecs[i].exp_gclk);
    end

    // DMG frequency window and phase lengths.
    do_reset(1'b0);
    repeat (30000) run_edge(1'b0, "dmg_seq");
    freq_check("dmg_freq", st_rises, 30000, 4194304);
    check("dmg_phase_min", st_min, 2);
    check("dmg_phase_max", st_max, 3);

    // CGB frequency window and phase lengths.
    do_reset(1'b1);
    repeat (30000) run_edge(1'b1, "cgb_seq");
    freq_check("cgb_freq", st_rises, 30000, 8388608);
    check("cgb_phase_min", st_min, 1);
    check("cgb_phase_max", st_max, 2);

    // Random mode runs against the model.
    do_reset(1'($urandom_range(0, 1)));
    remaining = 3000;
    while (remaining > 0) begin
      m   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      if (len > remaining) len = remaining;
      repeat (len) run_edge(m, "rand_seq");
      remaining -= len;
    end

    // Mode toggled every 37 edges: the model pins the one-edge switch latency.
    do_reset(1'b0);
    m = 1'b0;
    for (int k = 0; k < 16; k++) begin
      repeat (37) run_edge(m, "toggle_seq");
      m = ~m;
    end
    check_range("toggle_phase_min", st_min, 1, 3);
    check_range("toggle_phase_max", st_max, 1, 3);

    // Asynchronous reset mid-cycle while gclk is high.
    do_reset(1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run_edge(1'b0, "pre_rst_seq");
      if (gclk === 1'b1) found = 1'b1;
    end
    check("reach_gclk_high", found, 1);
    #2 rst = 1'b1;
    #1 check("async_rst_gclk", gclk, 0);
    tick();
    check("held_rst_gclk", gclk, 0);
    rst = 1'b0;
    model_reset();
    stats_reset();
    exp_q.delete();
    run_edge(1'b0, "post_rst_edge1");
    run_edge(1'b0, "post_rst_edge2");
    run_edge(1'b0, "post_rst_edge3");
    check("post_rst_edge3_high", gclk, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
